// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared ALU control codes. The same encoding is used by the operand decode
// in alu_core and by anything that issues operations to alu_pipe.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU evaluation.
//   a, b    : WIDTH-bit operands
//   op      : control code (alu_pkg encoding)
//   result  : WIDTH-bit result (0 for an unknown code)
//   cout    : carry out of the adder for ADD/SUB (SUB: 1 = no borrow)
//   ovf     : signed two's-complement overflow for ADD/SUB
//   err     : control code is not one of the defined operations
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [ALU_OP_W-1:0] op,
    output logic [WIDTH-1:0]    result,
    output logic                cout,
    output logic                ovf,
    output logic                err
);

    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic        [WIDTH:0]   add_full;
    logic        [WIDTH:0]   sub_full;
    logic                    lt;

    assign a_s = a;
    assign b_s = b;

    // One extra bit on each adder captures the carry out of bit WIDTH-1.
    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    // Signed compare directly rather than sign-of-difference, so the answer
    // stays right when a-b overflows.
    assign lt = (a_s < b_s);

    always_comb begin
        result = '0;
        cout   = 1'b0;
        ovf    = 1'b0;
        err    = 1'b0;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_NOR: result = ~(a | b);
            ALU_ADD: begin
                result = add_full[WIDTH-1:0];
                cout   = add_full[WIDTH];
                ovf    = add_ovf(a[WIDTH-1], b[WIDTH-1], add_full[WIDTH-1]);
            end
            ALU_SUB: begin
                result = sub_full[WIDTH-1:0];
                cout   = sub_full[WIDTH];
                ovf    = sub_ovf(a[WIDTH-1], b[WIDTH-1], sub_full[WIDTH-1]);
            end
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt};
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Two-stage ALU with valid/ready handshake on both sides.
//   Stage 1 holds the accepted op and operands, stage 2 holds result + flags.
//   clk, reset (sync, active-high), flush (sync pipeline clear)
//   in_valid / in_ready / in_op / in_a / in_b       : operation input
//   out_valid / out_ready / out_result              : result output
//   out_zero / out_cout / out_ovf / out_err         : result flags
// -----------------------------------------------------------------------------
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] in_op,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_result,
    output logic                out_zero,
    output logic                out_cout,
    output logic                out_ovf,
    output logic                out_err
);

    logic                vld_p1;
    logic [ALU_OP_W-1:0] op_p1;
    logic [WIDTH-1:0]    a_p1;
    logic [WIDTH-1:0]    b_p1;

    logic                vld_p2;
    logic [WIDTH-1:0]    result_p2;
    logic                zero_p2;
    logic                cout_p2;
    logic                ovf_p2;
    logic                err_p2;

    logic [WIDTH-1:0]    core_result;
    logic                core_cout;
    logic                core_ovf;
    logic                core_err;

    logic                s2_open;
    logic                s1_open;
    logic                take_in;
    logic                load_p2;

    // A stage can take new contents when it is empty or its contents leave
    // this cycle; this chains so a full pipe still streams one op per cycle.
    assign s2_open  = !vld_p2 || out_ready;
    assign s1_open  = !vld_p1 || s2_open;
    assign in_ready = s1_open && !flush;
    assign take_in  = in_valid && in_ready;
    assign load_p2  = s2_open && vld_p1 && !flush;

    // ---- stage 1: capture op and operands ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (s1_open) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (take_in) begin
            op_p1 <= in_op;
            a_p1  <= in_a;
            b_p1  <= in_b;
        end
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (a_p1),
        .b      (b_p1),
        .op     (op_p1),
        .result (core_result),
        .cout   (core_cout),
        .ovf    (core_ovf),
        .err    (core_err)
    );

    // ---- stage 2: register result and flags ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2 <= 1'b0;
        end else if (flush) begin
            vld_p2 <= 1'b0;
        end else if (s2_open) begin
            vld_p2 <= vld_p1;
        end
    end

    // Result and flags are visible on the output port, so they are cleared
    // by reset to give a clean, all-zero output after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_p2 <= '0;
            zero_p2   <= 1'b0;
            cout_p2   <= 1'b0;
            ovf_p2    <= 1'b0;
            err_p2    <= 1'b0;
        end else if (load_p2) begin
            result_p2 <= core_result;
            zero_p2   <= (core_result == '0);
            cout_p2   <= core_cout;
            ovf_p2    <= core_ovf;
            err_p2    <= core_err;
        end
    end

    assign out_valid  = vld_p2;
    assign out_result = result_p2;
    assign out_zero   = zero_p2;
    assign out_cout   = cout_p2;
    assign out_ovf    = ovf_p2;
    assign out_err    = err_p2;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        o;
        logic        e;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush;
    // 32-bit instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a, in_b, out_result;
    logic        out_zero, out_cout, out_ovf, out_err;
    // 8-bit instance
    logic        v8_in_valid, v8_in_ready, v8_out_valid, v8_out_ready;
    logic [3:0]  v8_in_op;
    logic [7:0]  v8_in_a, v8_in_b, v8_out_result;
    logic        v8_out_zero, v8_out_cout, v8_out_ovf, v8_out_err;

    alu_pipe #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_cout(out_cout), .out_ovf(out_ovf), .out_err(out_err)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(v8_in_valid), .in_ready(v8_in_ready), .in_op(v8_in_op),
        .in_a(v8_in_a), .in_b(v8_in_b),
        .out_valid(v8_out_valid), .out_ready(v8_out_ready), .out_result(v8_out_result),
        .out_zero(v8_out_zero), .out_cout(v8_out_cout), .out_ovf(v8_out_ovf), .out_err(v8_out_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on sign-extended values.
    function automatic longint sext(input longint unsigned v, input int w);
        longint t;
        t = longint'(v << (64 - w));
        return t >>> (64 - w);
    endfunction

    function automatic exp_t model(input int w, input logic [3:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        longint unsigned mask, ua, ub, s;
        longint sa, sb, t, maxv, minv;
        exp_t r;
        r    = '0;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = sext(ua, w);
        sb   = sext(ub, w);
        maxv = (64'sd1 <<< (w - 1)) - 64'sd1;
        minv = -(64'sd1 <<< (w - 1));
        case (op)
            4'b0000: r.res = 32'(ua & ub);
            4'b0001: r.res = 32'(ua | ub);
            4'b1100: r.res = 32'(~(ua | ub) & mask);
            4'b0010: begin
                s     = ua + ub;
                r.res = 32'(s & mask);
                r.c   = s[w];
                t     = sa + sb;
                r.o   = (t > maxv) || (t < minv);
            end
            4'b0110: begin
                s     = ua + (~ub & mask) + 64'd1;
                r.res = 32'(s & mask);
                r.c   = s[w];
                t     = sa - sb;
                r.o   = (t > maxv) || (t < minv);
            end
            4'b0111: r.res = (sa < sb) ? 32'd1 : 32'd0;
            default: r.e = 1'b1;
        endcase
        r.z = (r.res == 32'd0);
        return r;
    endfunction

    function automatic logic [3:0] pick_op();
        case ($urandom_range(0, 7))
            0: return ALU_AND;
            1: return ALU_OR;
            2: return ALU_ADD;
            3: return ALU_SUB;
            4: return ALU_SLT;
            5: return ALU_NOR;
            6: return 4'b0101;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    function automatic logic [31:0] pick_val(input int w);
        logic [31:0] top;
        top = 32'd1 << (w - 1);
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return top;
            3: return top - 32'd1;
            4: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboards, active only during the streaming phases.
    bit   mon32 = 0, mon8 = 0;
    exp_t q32[$], q8[$];
    exp_t e32, e8;
    int   cnt32 = 0, push32 = 0, cnt8 = 0, push8 = 0;

    always @(negedge clk) begin
        if (mon32) begin
            if (out_valid && out_ready) begin
                if (q32.size() == 0) chk("sb32_extra", q32.size(), 1);
                else begin
                    e32 = q32.pop_front();
                    chk("sb32", {out_zero, out_cout, out_ovf, out_err, out_result},
                        {e32.z, e32.c, e32.o, e32.e, e32.res});
                end
                cnt32++;
            end
            if (in_valid && in_ready) begin
                q32.push_back(model(32, in_op, in_a, in_b));
                push32++;
            end
        end
        if (mon8) begin
            if (v8_out_valid && v8_out_ready) begin
                if (q8.size() == 0) chk("sb8_extra", q8.size(), 1);
                else begin
                    e8 = q8.pop_front();
                    chk("sb8", {v8_out_zero, v8_out_cout, v8_out_ovf, v8_out_err, v8_out_result},
                        {e8.z, e8.c, e8.o, e8.e, e8.res[7:0]});
                end
                cnt8++;
            end
            if (v8_in_valid && v8_in_ready) begin
                q8.push_back(model(8, v8_in_op, {24'd0, v8_in_a}, {24'd0, v8_in_b}));
                push8++;
            end
        end
    end

    // Single op through an otherwise empty pipe, checking exact 2-cycle latency.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res,
                          input logic z, input logic c, input logic o, input logic e);
        @(posedge clk); #1;
        in_valid = 1; in_op = op; in_a = a; in_b = b; out_ready = 1;
        @(negedge clk);
        chk({tag, "_rdy"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        chk({tag, "_lat1"}, out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_res"}, out_result, res);
        chk({tag, "_flags"}, {out_zero, out_cout, out_ovf, out_err}, {z, c, o, e});
    endtask

    task automatic feed32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        in_valid = 1; in_op = op; in_a = a; in_b = b;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("feed_acc", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain32(input string tag);
        int n;
        n = 0;
        while (q32.size() != 0 && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        chk(tag, q32.size(), 0);
    endtask

    task automatic ghost_watch(input string tag);
        int seen;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1; flush = 0;
        in_valid = 0; in_op = 0; in_a = 0; in_b = 0; out_ready = 1;
        v8_in_valid = 0; v8_in_op = 0; v8_in_a = 0; v8_in_b = 0; v8_out_ready = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_vld", out_valid, 0);
        chk("rst_res", out_result, 0);
        chk("rst_flags", {out_zero, out_cout, out_ovf, out_err}, 4'b0000);
        chk("rst_rdy", in_ready, 1);
        chk("rst8_vld", v8_out_valid, 0);

        // Directed vectors
        run_op("add_ovf",  ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0, 1, 0);
        run_op("sub_eq",   ALU_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1, 1, 0, 0);
        run_op("slt_ovf",  ALU_SLT, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 0, 0, 0, 0);
        run_op("illegal",  4'b0101, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1, 0, 0, 1);
        run_op("and",      ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0, 0);
        run_op("or",       ALU_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0, 0, 0, 0);
        run_op("nor",      ALU_NOR, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0);
        run_op("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1, 0, 0);
        run_op("sub_brw",  ALU_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 0, 0);
        run_op("sub_ovf",  ALU_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 0, 1, 1, 0);
        run_op("slt_no",   ALU_SLT, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 1, 0, 0, 0);
        run_op("slt_neg",  ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0, 0, 0, 0);

        // Backpressure: 8 ops, consumer stalled
        @(posedge clk); #1;
        out_ready = 0;
        q32.delete(); cnt32 = 0; push32 = 0; mon32 = 1;
        feed32(ALU_ADD, 32'd0, 32'd100);
        feed32(ALU_ADD, 32'd1, 32'd100);
        in_valid = 1; in_op = ALU_ADD; in_a = 32'd2; in_b = 32'd100;
        repeat (3) begin
            @(negedge clk);
            chk("stall_rdy", in_ready, 0);
            chk("stall_vld", out_valid, 1);
            chk("stall_res", out_result, 32'd100);
        end
        chk("stall_accepted", push32, 2);
        @(posedge clk); #1;
        out_ready = 1;
        for (int k = 2; k < 8; k++) feed32(ALU_ADD, 32'(k), 32'd100);
        drain32("stall_drain");
        chk("stall_count", cnt32, 8);
        mon32 = 0;

        // Flush with two ops in flight
        @(posedge clk); #1;
        out_ready = 0;
        in_valid = 1; in_op = ALU_ADD; in_a = 32'd1; in_b = 32'd1;
        @(posedge clk); #1;
        in_op = ALU_SUB; in_a = 32'd9; in_b = 32'd3;
        @(posedge clk); #1;
        flush = 1; in_op = ALU_OR;
        @(negedge clk);
        chk("flush_full", out_valid, 1);
        chk("flush_rdy", in_ready, 0);
        @(posedge clk); #1;
        flush = 0; in_valid = 0; out_ready = 1;
        @(negedge clk);
        chk("flush_vld", out_valid, 0);
        ghost_watch("flush_ghost");

        // Reset mid-stream
        @(posedge clk); #1;
        out_ready = 0;
        in_valid = 1; in_op = ALU_NOR; in_a = 32'd0; in_b = 32'd0;
        @(posedge clk); #1;
        in_op = ALU_SUB; in_a = 32'd0; in_b = 32'd1;
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0; in_valid = 0; out_ready = 1;
        @(negedge clk);
        chk("mrst_vld", out_valid, 0);
        chk("mrst_res", out_result, 0);
        chk("mrst_flags", {out_zero, out_cout, out_ovf, out_err}, 4'b0000);
        chk("mrst_rdy", in_ready, 1);
        ghost_watch("mrst_ghost");

        // Random traffic, WIDTH=32
        q32.delete(); cnt32 = 0; push32 = 0; mon32 = 1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_op = pick_op(); in_a = pick_val(32); in_b = pick_val(32);
        end
        @(posedge clk); #1;
        in_valid = 0; out_ready = 1;
        drain32("rnd32_drain");
        chk("rnd32_count", cnt32, push32);
        mon32 = 0;

        // Random traffic, WIDTH=8
        q8.delete(); cnt8 = 0; push8 = 0; mon8 = 1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            v8_in_valid  = ($urandom_range(0, 3) != 0);
            v8_out_ready = ($urandom_range(0, 3) != 0);
            v8_in_op = pick_op(); v8_in_a = 8'(pick_val(8)); v8_in_b = 8'(pick_val(8));
        end
        @(posedge clk); #1;
        v8_in_valid = 0; v8_out_ready = 1;
        n = 0;
        while (q8.size() != 0 && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        chk("rnd8_drain", q8.size(), 0);
        chk("rnd8_count", cnt8, push8);
        mon8 = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
